// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Ripple-carry adder built from WIDTH 1-bit full-adder cells. Sum/Cout are
// purely combinational; sum_q/cout_q/ovf_q/out_valid are a registered,
// reset-clean copy with one cycle of latency for downstream clocked logic.
// -----------------------------------------------------------------------------
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             ovf_q,
    output logic             out_valid
);

    // carry[i] is the carry into cell i; carry[0] is Cin, carry[WIDTH] is Cout.
    logic [WIDTH:0] carry;
    logic           ovf;

    assign carry[0] = Cin;

    // One full-adder cell per bit: the sum bit is the parity of the three
    // inputs, the carry out is their majority. No masking, so X/Z on any
    // operand propagates straight through to Sum/Cout.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign Sum[i]     = In1[i] ^ In2[i] ^ carry[i];
        assign carry[i+1] = (In1[i] & In2[i]) | (In1[i] & carry[i]) | (In2[i] & carry[i]);
    end

    assign Cout = carry[WIDTH];

    // Two's-complement overflow: the carry into the sign bit disagrees with
    // the carry out of it. For WIDTH=1 the carry into the sign bit is Cin.
    assign ovf = carry[WIDTH] ^ carry[WIDTH-1];

    // Output register: capture the result on a valid input, otherwise hold
    // the last result and drop out_valid. Reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignment so every register samples the
            // pre-edge values and the update order inside the block is irrelevant.
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q  <= Sum;
                cout_q <= Cout;
                ovf_q  <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
// Three instances (WIDTH 1, 4, 8) share clk and rst_n. An arithmetic model
// (plain integer add, signed range check) predicts combinational and
// registered outputs; one compare process checks all instances on every
// falling edge, and directed sequences add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_full_adder;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;
    bit run_cmp  = 1'b0;

    // WIDTH=1 instance
    logic [0:0] a1, b1, s1, sq1;
    logic       c1, v1, co1, cq1, oq1, ov1;
    // WIDTH=4 instance
    logic [3:0] a4, b4, s4, sq4;
    logic       c4, v4, co4, cq4, oq4, ov4;
    // WIDTH=8 instance
    logic [7:0] a8, b8, s8, sq8;
    logic       c8, v8, co8, cq8, oq8, ov8;

    full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .In1(a1), .In2(b1), .Cin(c1), .in_valid(v1),
        .Sum(s1), .Cout(co1), .sum_q(sq1), .cout_q(cq1), .ovf_q(oq1), .out_valid(ov1)
    );
    full_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .In1(a4), .In2(b4), .Cin(c4), .in_valid(v4),
        .Sum(s4), .Cout(co4), .sum_q(sq4), .cout_q(cq4), .ovf_q(oq4), .out_valid(ov4)
    );
    full_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .In1(a8), .In2(b8), .Cin(c8), .in_valid(v8),
        .Sum(s8), .Cout(co8), .sum_q(sq8), .cout_q(cq8), .ovf_q(oq8), .out_valid(ov8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: {ovf, cout, sum[7:0]} for a w-bit add, from integer arithmetic.
    function automatic logic [9:0] ref_add(input int w, input logic [7:0] a,
                                           input logic [7:0] b, input logic c);
        int ua, ub, full, lim, sa, sb, ss;
        logic [7:0] s;
        logic co, ov;
        ua   = int'(a);
        ub   = int'(b);
        full = ua + ub + int'(c);
        s    = 8'(full % (1 << w));
        co   = ((full >> w) != 0);
        lim  = 1 << (w - 1);
        sa   = (ua >= lim) ? ua - (1 << w) : ua;
        sb   = (ub >= lim) ? ub - (1 << w) : ub;
        ss   = sa + sb + int'(c);
        ov   = (ss >= lim) || (ss < -lim);
        return {ov, co, s};
    endfunction

    // Expected registered state per instance: {valid, ovf, cout, sum[7:0]}.
    logic [10:0] e1, e4, e8;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1 <= '0;
            e4 <= '0;
            e8 <= '0;
        end else begin
            e1 <= v1 ? {1'b1, ref_add(1, 8'(a1), 8'(b1), c1)} : {1'b0, e1[9:0]};
            e4 <= v4 ? {1'b1, ref_add(4, 8'(a4), 8'(b4), c4)} : {1'b0, e4[9:0]};
            e8 <= v8 ? {1'b1, ref_add(8, a8, b8, c8)}        : {1'b0, e8[9:0]};
        end
    end

    // Compare process: combinational and registered outputs of all instances.
    always @(negedge clk) begin
        if (run_cmp) begin
            logic [9:0] r;
            r = ref_add(1, 8'(a1), 8'(b1), c1);
            check("w1_comb", 32'({co1, 8'(s1)}), 32'(r[8:0]));
            r = ref_add(4, 8'(a4), 8'(b4), c4);
            check("w4_comb", 32'({co4, 8'(s4)}), 32'(r[8:0]));
            r = ref_add(8, a8, b8, c8);
            check("w8_comb", 32'({co8, s8}), 32'(r[8:0]));
            check("w1_reg", 32'({ov1, oq1, cq1, 8'(sq1)}), 32'(e1));
            check("w4_reg", 32'({ov4, oq4, cq4, 8'(sq4)}), 32'(e4));
            check("w8_reg", 32'({ov8, oq8, cq8, sq8}),     32'(e8));
        end
    end

    // WIDTH=4 directed case: comb check now, registered check after the edge.
    task automatic w4_case(input logic [3:0] a, input logic [3:0] b, input logic c,
                           input logic [4:0] exp_comb, input logic exp_ovf);
        a4 = a; b4 = b; c4 = c; v4 = 1'b1;
        #1;
        check("w4_dir_comb", 32'({co4, s4}), 32'(exp_comb));
        @(posedge clk); #1;
        check("w4_dir_reg", 32'({ov4, oq4, cq4, sq4}), 32'({1'b1, exp_ovf, exp_comb}));
    endtask

    logic [1:0] tab [8];

    initial begin
        tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        a1 = '0; b1 = '0; c1 = 1'b0; v1 = 1'b0;
        a4 = '0; b4 = '0; c4 = 1'b0; v4 = 1'b0;
        a8 = '0; b8 = '0; c8 = 1'b0; v8 = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        run_cmp = 1'b1;

        // Model pins: hand-computed results for the reference itself.
        check("model_7p1",  32'(ref_add(4, 8'h07, 8'h01, 1'b0)), 32'(10'b10_0000_1000));
        check("model_fpf1", 32'(ref_add(4, 8'h0F, 8'h0F, 1'b1)), 32'(10'b01_0000_1111));
        check("model_w1",   32'(ref_add(1, 8'h01, 8'h01, 1'b1)), 32'(10'b01_0000_0001));

        // Reset state, with valid inputs present during reset.
        v1 = 1'b1; a1 = 1'b1;
        @(posedge clk); #1;
        check("reset_state_w1", 32'({ov1, oq1, cq1, sq1}), 32'h0);
        check("reset_state_w8", 32'({ov8, oq8, cq8, sq8}), 32'h0);
        v1 = 1'b0; a1 = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;

        // WIDTH=1 exhaustive combinational, stepping away from clock edges.
        @(posedge clk); #2;
        {a1, b1, c1} = 3'b000;
        #100;
        check("w1_exh_000", 32'({co1, s1}), 32'(tab[0]));
        for (int k = 1; k < 8; k++) begin
            {a1, b1, c1} = 3'(k);
            #1;
            check($sformatf("w1_exh_%03b", 3'(k)), 32'({co1, s1}), 32'(tab[k]));
            #19;
        end

        // WIDTH=1 registered capture and hold.
        @(posedge clk); #1;
        {a1, b1, c1} = 3'b111; v1 = 1'b1;
        @(posedge clk); #1;
        check("w1_capture", 32'({ov1, sq1, cq1, oq1}), 32'b1110);
        v1 = 1'b0;
        @(posedge clk); #1;
        check("w1_hold", 32'({ov1, sq1, cq1, oq1}), 32'b0110);

        // Asynchronous reset between edges while out_valid=1, sum_q=1.
        v1 = 1'b1;
        @(posedge clk); #3;
        check("w1_pre_reset", 32'({ov1, sq1}), 32'b11);
        rst_n = 1'b0;
        #1;
        check("w1_async_reset", 32'({ov1, oq1, cq1, sq1}), 32'h0);
        check("w1_comb_in_reset", 32'({co1, s1}), 32'b11);
        {a1, b1, c1} = 3'b010;
        #1;
        check("w1_comb_track_reset", 32'({co1, s1}), 32'b01);
        @(posedge clk); #1;
        check("w1_reset_wins", 32'({ov1, oq1, cq1, sq1}), 32'h0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("w1_first_capture", 32'({ov1, sq1, cq1, oq1}), 32'b1100);
        v1 = 1'b0;

        // WIDTH=4 wrap and overflow.
        w4_case(4'hF, 4'h1, 1'b0, 5'h10, 1'b0);
        w4_case(4'h7, 4'h1, 1'b0, 5'h08, 1'b1);
        w4_case(4'hF, 4'hF, 1'b1, 5'h1F, 1'b0);
        w4_case(4'h0, 4'h0, 1'b0, 5'h00, 1'b0);
        v4 = 1'b0;

        // Back-to-back throughput at WIDTH=4.
        @(posedge clk); #1;
        a4 = 4'd3; b4 = 4'd4; c4 = 1'b0; v4 = 1'b1;
        @(posedge clk); #1;
        check("b2b_0", 32'({ov4, cq4, sq4}), 32'({1'b1, 1'b0, 4'h7}));
        a4 = 4'd9; b4 = 4'd9; c4 = 1'b1;
        @(posedge clk); #1;
        check("b2b_1", 32'({ov4, oq4, cq4, sq4}), 32'({1'b1, 1'b1, 1'b1, 4'h3}));
        a4 = 4'd0; b4 = 4'd0; c4 = 1'b0;
        @(posedge clk); #1;
        check("b2b_2", 32'({ov4, cq4, sq4}), 32'({1'b1, 1'b0, 4'h0}));
        v4 = 1'b0;
        @(posedge clk); #1;
        check("b2b_idle", 32'({ov4, sq4}), 32'h0);

        // Random vectors; the compare process checks comb and registered paths.
        repeat (1000) begin
            @(posedge clk); #1;
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom_range(0, 1));
            v8 = ($urandom_range(0, 7) != 0);
            a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom_range(0, 1));
            v4 = 1'($urandom_range(0, 1));
            a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
